// File: rtl/ripple_cnt_sampler_if.sv
// Update handshake bundle between the ripple sampler and its consumer.
// The master presents cnt_out/upd_valid; the slave answers with upd_ready.
interface ripple_cnt_sampler_if #(
  parameter int N = 8
);
  logic [N-1:0] cnt_out;
  logic         upd_valid;
  logic         upd_ready;

  modport master (
    output cnt_out,
    output upd_valid,
    input  upd_ready
  );

  modport slave (
    input  cnt_out,
    input  upd_valid,
    output upd_ready
  );
endinterface

// File: rtl/ripple_cnt_sampler.sv
// Samples an async ripple counter, filters transients, extends it on wraps.
// Define RIPPLE_SAMPLER_MATCH_EN to build the thresh compare / match pulse.
module ripple_cnt_sampler #(
  parameter int W      = 4,
  parameter int EXT    = 4,
  parameter int STABLE = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [W-1:0]       rip_in,
  input  logic [W+EXT-1:0]   thresh,
  ripple_cnt_sampler_if.master upd,
  output logic               match,
  output logic               miss
);

  localparam int N  = W + EXT;
  localparam int SW = $clog2(STABLE + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE - 1);
  localparam logic [SW-1:0] STAB_SAT  = SW'(STABLE);

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  logic [W-1:0]   r_s1;
  logic [W-1:0]   r_s2;
  logic [W-1:0]   r_cand;
  logic [SW-1:0]  r_stab;
  logic [W-1:0]   r_acc;
  logic [EXT-1:0] r_ext;
  logic [N-1:0]   r_cnt;
  logic [N-1:0]   r_shadow;
  logic           r_valid;
  logic           r_pend;
  logic           r_miss;
  state_t         r_state;

  logic           w_accept;
  logic           w_chg;
  logic           w_wrap;
  logic [EXT-1:0] w_ext_nx;
  logic [N-1:0]   w_trk;

  state_t         w_state_nx;
  logic [N-1:0]   w_cnt_nx;
  logic [N-1:0]   w_shadow_nx;
  logic           w_valid_nx;
  logic           w_pend_nx;
  logic           w_miss_nx;

  // stab_cnt saturates past STABLE-1 so each candidate is accepted once
  assign w_accept = (r_s2 == r_cand) && (r_stab == STAB_LAST);
  assign w_chg    = w_accept && (r_cand != r_acc);
  assign w_wrap   = r_cand < r_acc;
  assign w_ext_nx = w_wrap ? r_ext + EXT'(1) : r_ext;
  assign w_trk    = {w_ext_nx, r_cand};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_cand <= '0;
      r_stab <= '0;
    end else begin
      r_s1 <= rip_in;
      r_s2 <= r_s1;
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_stab <= '0;
      end else if (r_stab == STAB_LAST) begin
        r_stab <= STAB_SAT;
      end else if (r_stab < STAB_LAST) begin
        r_stab <= r_stab + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_acc <= '0;
      r_ext <= '0;
    end else if (w_chg) begin
      r_acc <= r_cand;
      r_ext <= w_ext_nx;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_valid  <= 1'b0;
      r_pend   <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_shadow <= w_shadow_nx;
      r_valid  <= w_valid_nx;
      r_pend   <= w_pend_nx;
      r_miss   <= w_miss_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_shadow_nx = r_shadow;
    w_valid_nx  = r_valid;
    w_pend_nx   = r_pend;
    w_miss_nx   = r_miss;
    unique case (r_state)
      IDLE: begin
        if (w_chg) begin
          w_cnt_nx   = w_trk;
          w_valid_nx = 1'b1;
          w_state_nx = PEND;
        end
      end
      PEND: begin
        if (upd.upd_ready) begin
          if (w_chg) begin
            w_cnt_nx  = w_trk;
            w_pend_nx = 1'b0;
            if (r_pend) w_miss_nx = 1'b1;
          end else if (r_pend) begin
            w_cnt_nx  = r_shadow;
            w_pend_nx = 1'b0;
          end else begin
            w_valid_nx = 1'b0;
            w_state_nx = IDLE;
          end
        end else if (w_chg) begin
          // a still-unread shadow value gets overwritten here
          w_shadow_nx = w_trk;
          w_pend_nx   = 1'b1;
          if (r_pend) w_miss_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign upd.cnt_out   = r_cnt;
  assign upd.upd_valid = r_valid;
  assign miss          = r_miss;

`ifdef RIPPLE_SAMPLER_MATCH_EN
  logic r_match;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_match <= 1'b0;
    else     r_match <= w_chg && (w_trk == thresh);
  end

  assign match = r_match;
`else
  logic w_unused_thresh;

  assign w_unused_thresh = ^thresh;
  assign match           = 1'b0;
`endif

endmodule
